// File: rtl/dmem_arbiter.sv
// Purpose : shares the single-port data memory between the CPU MEM stage (priority) and a debug/loader port.
// Latency : CPU read data is combinational (zero cycles); DBG read data is registered, valid one cycle after accept.
// Backpr. : CPU stalls only during a forced DBG grant; DBG is held off with dbg_ready=0 while the CPU owns memory.
//
// Optional feature: define DMEM_ARB_STARVE_GUARD_EN to build the starvation guard (wait counter + ARB_FORCE).
//   Without it the CPU has strict priority and DBG may wait indefinitely.
//
// Ports:
//   clk, reset                          clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata -> cpu_rdata  MEM stage access, cpu_stall holds the pipeline
//   dbg_valid/we/addr/wdata, dbg_ready  DBG valid/ready request channel
//   dbg_rdata, dbg_rvalid               registered DBG read return (one-cycle pulse)
//   mem_we/addr/wdata, mem_rdata        single-port data memory interface
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  dbg_valid,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ready,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_rvalid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // The wait counter is 8 bits wide, which bounds the usable limit.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be in 1..255");
    end

    // High while the one-cycle forced DBG grant is in effect.
    logic in_force;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic {
        ARB_CPU   = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_t;

    arb_state_t state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;

    // Counts cycles a valid DBG request is refused; any accept or an idle DBG clears it.
    always_comb begin
        wait_cnt_nxt = 8'd0;
        if (dbg_valid && !dbg_ready) begin
            wait_cnt_nxt = (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB_CPU;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: the edge at which the count reaches the limit moves us into the
    // forced grant, so after LIMIT refused cycles the next cycle belongs to DBG.
    // ARB_FORCE always lasts exactly one cycle.
    always_comb begin
        state_nxt = ARB_CPU;
        if (state == ARB_CPU && dbg_valid && wait_cnt_nxt == LIMIT) begin
            state_nxt = ARB_FORCE;
        end
    end

    assign in_force = (state == ARB_FORCE);
`else
    assign in_force = 1'b0;
`endif

    // Output logic: ownership, handshakes and memory drive.
    logic cpu_own;
    logic dbg_own;

    always_comb begin
        cpu_own   = 1'b0;
        dbg_own   = 1'b0;
        cpu_stall = 1'b0;
        dbg_ready = 1'b0;
        if (in_force) begin
            dbg_own   = 1'b1;
            dbg_ready = 1'b1;
            cpu_stall = cpu_req;
        end else if (cpu_req) begin
            cpu_own = 1'b1;
        end else if (dbg_valid) begin
            dbg_own   = 1'b1;
            dbg_ready = 1'b1;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (dbg_own) begin
            // Gate with dbg_valid so a forced grant never writes on an empty request.
            mem_we    = dbg_we & dbg_valid;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (cpu_own) begin
            mem_we = cpu_we;
        end
    end

    assign cpu_rdata = mem_rdata;

    // DBG read return: capture memory data on an accepted read, pulse rvalid for one cycle.
    logic dbg_rd_acc;
    assign dbg_rd_acc = dbg_valid & dbg_ready & ~dbg_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            dbg_rvalid <= dbg_rd_acc;
            if (dbg_rd_acc) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : directed checks of dmem_arbiter against a small behavioural data memory.
// Latency : inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
// Backpr. : DBG requests are held stable while refused, as the handshake requires.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dbg_valid, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ready;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_rvalid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Word-addressed data memory: combinational read, synchronous write.
    logic [DW-1:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        creq, cwe;
        logic [31:0] caddr, cwd;
        logic        dval, dwe;
        logic [31:0] daddr, dwd;
        logic        e_stall, e_rdy, e_we;
        logic [31:0] e_addr;
        logic        chk_rd;
        logic [31:0] e_crd;
        logic        e_rv;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
        input logic dval, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
        input logic e_stall, input logic e_rdy, input logic e_we, input logic [31:0] e_addr,
        input logic chk_rd, input logic [31:0] e_crd, input logic e_rv, input logic [31:0] e_rd);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dval = dval; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
        v.e_stall = e_stall; v.e_rdy = e_rdy; v.e_we = e_we; v.e_addr = e_addr;
        v.chk_rd = chk_rd; v.e_crd = e_crd; v.e_rv = e_rv; v.e_rd = e_rd;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin
        //            creq cwe caddr  cwd           dval dwe daddr  dwd           stl rdy we addr   chk crd           rv rd
        vecs[0]  = mk(0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 0, 32'h0,        0, 32'h0);
        vecs[1]  = mk(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h00, 32'h0,        0, 0, 1, 32'h10, 0, 32'h0,        0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h10, 32'h0,        1, 1, 32'h20, 32'h12345678, 0, 1, 1, 32'h20, 0, 32'h0,        0, 32'h0);
        vecs[3]  = mk(0, 0, 32'h10, 32'h0,        1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 1, 32'h12345678, 0, 32'h0);
        vecs[4]  = mk(0, 0, 32'h20, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h20, 1, 32'h12345678, 1, 32'h12345678);
        vecs[5]  = mk(1, 0, 32'h20, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h20, 1, 32'h12345678, 0, 32'h12345678);
        vecs[6]  = mk(1, 0, 32'h10, 32'h0,        1, 0, 32'h20, 32'h0,        0, 0, 0, 32'h10, 1, 32'hDEADBEEF, 0, 32'h12345678);
        vecs[7]  = mk(0, 0, 32'h10, 32'h0,        1, 0, 32'h20, 32'h0,        0, 1, 0, 32'h20, 1, 32'h12345678, 0, 32'h12345678);
        vecs[8]  = mk(1, 1, 32'h30, 32'hA5A5A5A5, 1, 0, 32'h10, 32'h0,        0, 0, 1, 32'h30, 0, 32'h0,        1, 32'h12345678);
        vecs[9]  = mk(0, 0, 32'h30, 32'h0,        1, 0, 32'h10, 32'h0,        0, 1, 0, 32'h10, 1, 32'hDEADBEEF, 0, 32'h12345678);
        vecs[10] = mk(0, 0, 32'h30, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h30, 1, 32'hA5A5A5A5, 1, 32'hDEADBEEF);
        vecs[11] = mk(0, 0, 32'h30, 32'h0,        1, 1, 32'h40, 32'h0BADF00D, 0, 1, 1, 32'h40, 0, 32'h0,        0, 32'hDEADBEEF);
        vecs[12] = mk(0, 0, 32'h30, 32'h0,        1, 0, 32'h40, 32'h0,        0, 1, 0, 32'h40, 1, 32'h0BADF00D, 0, 32'hDEADBEEF);
        vecs[13] = mk(0, 0, 32'h30, 32'h0,        1, 0, 32'h30, 32'h0,        0, 1, 0, 32'h30, 1, 32'hA5A5A5A5, 1, 32'h0BADF00D);
        vecs[14] = mk(0, 0, 32'h30, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h30, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5);
        vecs[15] = mk(0, 0, 32'h30, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h30, 1, 32'hA5A5A5A5, 0, 32'hA5A5A5A5);

        // Reset held with the CPU requesting.
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        #3;
        chk("rst_rvalid", 32'(dbg_rvalid), 32'h0);
        chk("rst_rdata", dbg_rdata, 32'h0);
        chk("rst_stall", 32'(cpu_stall), 32'h0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        // Table-driven vectors, one per cycle.
        for (int i = 0; i < 16; i++) begin
            cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe;
            cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
            dbg_valid = vecs[i].dval; dbg_we = vecs[i].dwe;
            dbg_addr = vecs[i].daddr; dbg_wdata = vecs[i].dwd;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_ready", i), 32'(dbg_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
            if (vecs[i].chk_rd) chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
            chk($sformatf("v%0d_rvalid", i), 32'(dbg_rvalid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_rdata", i), dbg_rdata, vecs[i].e_rd);
            @(posedge clk); #1;
        end

        // Reset mid-operation drops a pending rvalid; the held DBG request is re-arbitrated.
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h30;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        @(negedge clk);
        chk("mid_ready", 32'(dbg_ready), 32'h1);
        @(posedge clk); #1;
        chk("mid_pre_rvalid", 32'(dbg_rvalid), 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(dbg_rvalid), 32'h0);
        chk("mid_rst_rdata", dbg_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(dbg_ready), 32'h1);
        chk("post_rst_addr", mem_addr, 32'h20);
        @(posedge clk); #1;
        chk("post_rst_rvalid", 32'(dbg_rvalid), 32'h1);
        chk("post_rst_rdata", dbg_rdata, 32'h12345678);
        dbg_valid = 1'b0;
        @(posedge clk); #1;

        // CPU and DBG both requesting continuously.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        // Four refused cycles, one forced grant, then the count restarts from zero.
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk($sformatf("starve_c%0d_ready", c), 32'(dbg_ready), (c == 5 || c == 10) ? 32'h1 : 32'h0);
            chk($sformatf("starve_c%0d_stall", c), 32'(cpu_stall), (c == 5 || c == 10) ? 32'h1 : 32'h0);
            if (c == 5) chk("starve_force_addr", mem_addr, 32'h40);
            if (c == 6) begin
                chk("starve_rvalid", 32'(dbg_rvalid), 32'h1);
                chk("starve_rdata", dbg_rdata, 32'h0BADF00D);
            end
            @(posedge clk); #1;
        end
`else
        // Strict priority: DBG is never granted and the CPU never stalls.
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            chk($sformatf("prio_c%0d_ready", c), 32'(dbg_ready), 32'h0);
            chk($sformatf("prio_c%0d_stall", c), 32'(cpu_stall), 32'h0);
            @(posedge clk); #1;
        end
        chk("prio_rvalid", 32'(dbg_rvalid), 32'h0);
`endif
        dbg_valid = 1'b0;
        cpu_req = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
